periph_bus_arbiter: RTL

Two-requester arbiter sharing one memory-mapped peripheral request port (timer and sibling register-bank peripherals) between the core data port (requester 0) and a secondary master such as a debug or DMA unit (requester 1). Single-cycle transactions are granted round-robin. An optional lock lets a requester hold the bus for atomic multi-access sequences, for example stopping the timer, loading it, then re-enabling it. A bounded hold counter prevents starvation.

---
 rtl/periph_bus_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - two-requester round-robin peripheral bus arbiter
// Optional lock/hold-limit logic enabled by defining PERIPH_ARB_LOCK_EN.
module periph_bus_arbiter #(
  parameter int LOCK_MAX_CYCLES = 16,
  parameter int ADDR_W          = 32,
  parameter int WORD_W          = 32,
  parameter int MEM_COUNT_W     = 2,
  parameter int MEM_CODE_W      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_m0_req_valid,
  input  logic                   i_m0_req_lock,
  input  logic [ADDR_W-1:0]      i_m0_req_addr,
  input  logic [WORD_W-1:0]      i_m0_req_wr_data,
  input  logic                   i_m0_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_m0_req_count,
  input  logic                   i_m1_req_valid,
  input  logic                   i_m1_req_lock,
  input  logic [ADDR_W-1:0]      i_m1_req_addr,
  input  logic [WORD_W-1:0]      i_m1_req_wr_data,
  input  logic                   i_m1_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_m1_req_count,
  output logic                   o_m0_grant,
  output logic                   o_m1_grant,
  output logic [WORD_W-1:0]      o_m0_res_rd_data,
  output logic [WORD_W-1:0]      o_m1_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_m0_res_code,
  output logic [MEM_CODE_W-1:0]  o_m1_res_code,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);

  logic any_gnt;
  logic gnt_id;
  logic last_grant_q, last_grant_d;

`ifdef PERIPH_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_MAX_CYCLES);

  lock_state_e state_q, state_d;
  logic        owner_id_q, owner_id_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        block_relock_q, block_relock_d;
  logic        owner_active;
  logic        gnt_lock;
  logic        other_valid;
  logic [7:0]  hold_nx;

  assign owner_active = (state_q == LOCKED) &&
                        (owner_id_q ? i_m1_req_valid : i_m0_req_valid);
  assign gnt_lock     = gnt_id ? i_m1_req_lock : i_m0_req_lock;
  assign other_valid  = gnt_id ? i_m0_req_valid : i_m1_req_valid;
  assign hold_nx      = hold_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= UNLOCKED;
      owner_id_q     <= 1'b0;
      hold_cnt_q     <= 8'd0;
      block_relock_q <= 1'b0;
      last_grant_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      owner_id_q     <= owner_id_d;
      hold_cnt_q     <= hold_cnt_d;
      block_relock_q <= block_relock_d;
      last_grant_q   <= last_grant_d;
    end
  end

  // Owner absence falls through to the unlocked branch so the other side can win this cycle.
  always_comb begin
    state_d        = state_q;
    owner_id_d     = owner_id_q;
    hold_cnt_d     = hold_cnt_q;
    block_relock_d = block_relock_q;
    last_grant_d   = last_grant_q;
    if (any_gnt) begin
      last_grant_d = gnt_id;
      if (block_relock_q && (gnt_id != owner_id_q)) block_relock_d = 1'b0;
    end
    if (owner_active) begin
      if (!gnt_lock) begin
        state_d    = UNLOCKED;
        hold_cnt_d = 8'd0;
      end else if (hold_nx >= LOCK_MAX) begin
        state_d        = UNLOCKED;
        hold_cnt_d     = 8'd0;
        block_relock_d = other_valid;
      end else begin
        hold_cnt_d = hold_nx;
      end
    end else begin
      state_d    = UNLOCKED;
      hold_cnt_d = 8'd0;
      if (any_gnt && gnt_lock && !(block_relock_q && (gnt_id == owner_id_q))) begin
        owner_id_d = gnt_id;
        if (LOCK_MAX <= 8'd1) begin
          block_relock_d = other_valid;
        end else begin
          state_d    = LOCKED;
          hold_cnt_d = 8'd1;
        end
      end
    end
  end

  always_comb begin
    any_gnt = 1'b0;
    gnt_id  = 1'b0;
    if (owner_active) begin
      any_gnt = 1'b1;
      gnt_id  = owner_id_q;
    end else if (i_m0_req_valid && i_m1_req_valid) begin
      any_gnt = 1'b1;
      gnt_id  = block_relock_q ? ~owner_id_q : ~last_grant_q;
    end else if (i_m0_req_valid || i_m1_req_valid) begin
      any_gnt = 1'b1;
      gnt_id  = i_m1_req_valid;
    end
    if (reset) any_gnt = 1'b0;
  end
`else
  logic unused_lock;
  assign unused_lock = i_m0_req_lock ^ i_m1_req_lock ^ (LOCK_MAX_CYCLES == 0);

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (any_gnt) last_grant_d = gnt_id;
  end

  always_comb begin
    any_gnt = 1'b0;
    gnt_id  = 1'b0;
    if (i_m0_req_valid && i_m1_req_valid) begin
      any_gnt = 1'b1;
      gnt_id  = ~last_grant_q;
    end else if (i_m0_req_valid || i_m1_req_valid) begin
      any_gnt = 1'b1;
      gnt_id  = i_m1_req_valid;
    end
    if (reset) any_gnt = 1'b0;
  end
`endif

  always_comb begin
    o_m0_grant       = any_gnt && !gnt_id;
    o_m1_grant       = any_gnt && gnt_id;
    o_req_addr       = '0;
    o_req_wr_data    = '0;
    o_req_wr_en      = 1'b0;
    o_req_count      = '0;
    o_m0_res_rd_data = '0;
    o_m0_res_code    = '0;
    o_m1_res_rd_data = '0;
    o_m1_res_code    = '0;
    if (o_m1_grant) begin
      o_req_addr       = i_m1_req_addr;
      o_req_wr_data    = i_m1_req_wr_data;
      o_req_wr_en      = i_m1_req_wr_en;
      o_req_count      = i_m1_req_count;
      o_m1_res_rd_data = i_res_rd_data;
      o_m1_res_code    = i_res_code;
    end else if (o_m0_grant) begin
      o_req_addr       = i_m0_req_addr;
      o_req_wr_data    = i_m0_req_wr_data;
      o_req_wr_en      = i_m0_req_wr_en;
      o_req_count      = i_m0_req_count;
      o_m0_res_rd_data = i_res_rd_data;
      o_m0_res_code    = i_res_code;
    end
  end

endmodule
